// File: rtl/seq_emitter.sv
// seq_emitter
//   Emits a stream of 2-bit symbols, one per clock. A command (start with cnt,
//   hold) emits `cnt` patterns, one after another. Each pattern is the symbol
//   01, then 10, then 11, then `hold` extra 11 symbols. Consecutive patterns
//   are separated by GAP_LEN symbols of 00. A command with cnt == 0 emits
//   nothing and only produces the done pulse.
//
// Parameters
//   GAP_LEN  number of 00 symbols between consecutive patterns (1..3)
//
// Ports
//   clk      in   sole clock, rising edge
//   reset    in   asynchronous, active-high reset
//   start    in   command request, sampled only in IDLE
//   cnt      in   [3:0] number of patterns, sampled with start
//   hold     in   [1:0] extra 11 symbols per pattern, sampled with start
//   num      out  [1:0] symbol stream
//   busy     out  high while a command executes
//   done     out  one-cycle completion pulse, in the first IDLE cycle
//   emitted  out  [3:0] patterns completed for the current or last command
//
// num, busy and done are decoded from registered state only. No input reaches
// them combinationally.
module seq_emitter #(
  parameter int GAP_LEN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] cnt,
  input  logic [1:0] hold,
  output logic [1:0] num,
  output logic       busy,
  output logic       done,
  output logic [3:0] emitted
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    HOLD = 3'd4,
    GAP  = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_remaining;
  logic [3:0] w_remaining_next;
  logic [1:0] r_hold;
  logic [1:0] w_hold_next;
  logic [1:0] r_hold_ctr;
  logic [1:0] w_hold_ctr_next;
  logic [1:0] r_gap_ctr;
  logic [1:0] w_gap_ctr_next;
  logic [3:0] r_emitted;
  logic [3:0] w_emitted_next;
  logic       r_done;
  logic       w_done_next;
  logic       w_pattern_end;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= 4'd0;
      r_hold      <= 2'd0;
      r_hold_ctr  <= 2'd0;
      r_gap_ctr   <= 2'd0;
      r_emitted   <= 4'd0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_hold      <= w_hold_next;
      r_hold_ctr  <= w_hold_ctr_next;
      r_gap_ctr   <= w_gap_ctr_next;
      r_emitted   <= w_emitted_next;
      r_done      <= w_done_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_hold_next      = r_hold;
    w_hold_ctr_next  = r_hold_ctr;
    w_gap_ctr_next   = r_gap_ctr;
    w_emitted_next   = r_emitted;
    w_done_next      = 1'b0;
    w_pattern_end    = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_emitted_next = 4'd0;
          if (cnt != 4'd0) begin
            w_remaining_next = cnt;
            w_hold_next      = hold;
            w_state_next     = S1;
          end else begin
            // An empty command still completes. The pulse appears in the
            // next IDLE cycle, the same way it does for a real command.
            w_done_next = 1'b1;
          end
        end
      end
      S1: w_state_next = S2;
      S2: w_state_next = S3;
      S3: begin
        if (r_hold != 2'd0) begin
          w_hold_ctr_next = r_hold;
          w_state_next    = HOLD;
        end else begin
          w_pattern_end = 1'b1;
        end
      end
      HOLD: begin
        w_hold_ctr_next = r_hold_ctr - 2'd1;
        if (r_hold_ctr == 2'd1) begin
          w_pattern_end = 1'b1;
        end
      end
      GAP: begin
        w_gap_ctr_next = r_gap_ctr - 2'd1;
        if (r_gap_ctr == 2'd1) begin
          w_state_next = S1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Pattern completion is shared by S3 (hold == 0) and the last HOLD cycle.
    if (w_pattern_end) begin
      w_emitted_next   = r_emitted + 4'd1;
      w_remaining_next = r_remaining - 4'd1;
      if (r_remaining == 4'd1) begin
        w_state_next = IDLE;
        w_done_next  = 1'b1;
      end else begin
        w_gap_ctr_next = 2'(GAP_LEN);
        w_state_next   = GAP;
      end
    end
  end

  // Moore output decode
  always_comb begin
    num  = 2'b00;
    busy = 1'b1;
    case (r_state)
      IDLE:    begin num = 2'b00; busy = 1'b0; end
      S1:      num = 2'b01;
      S2:      num = 2'b10;
      S3:      num = 2'b11;
      HOLD:    num = 2'b11;
      GAP:     num = 2'b00;
      default: begin num = 2'b00; busy = 1'b0; end
    endcase
  end

  assign done    = r_done;
  assign emitted = r_emitted;

endmodule

// File: doc/seq_emitter.md
SEQ_EMITTER -- requirements
Module: seq_emitter

Interface
REQ-001 Parameter GAP_LEN, default 1, meaning number of 2'b00 symbols inserted between consecutive patterns; legal range 1..3.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  command request; sampled on posedge clk.
REQ-005 cnt  input  4  number of patterns to emit; sampled with start.
REQ-006 hold  input  2  number of extra 2'b11 symbols after each pattern's first 2'b11; sampled with start.
REQ-007 num  output  2  emitted symbol stream, one symbol per cycle.
REQ-008 busy  output  1  high while a command is executing.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 emitted  output  4  count of patterns completed for the current or last command.

Function
REQ-011 The block SHALL be a Moore FSM: num, busy and done SHALL be decoded from registered state only, with no combinational path from any input.
REQ-012 States SHALL be IDLE, S1, S2, S3, HOLD, GAP; num SHALL be 00 in IDLE, 01 in S1, 10 in S2, 11 in S3 and HOLD, and 00 in GAP.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 In IDLE, start=1 with cnt!=0 SHALL latch cnt into remaining, latch hold, clear emitted, and enter S1; num=01 SHALL appear in the cycle after the sampling edge.
REQ-015 In IDLE, start=1 with cnt==0 SHALL clear emitted, stay in IDLE, and pulse done for exactly the following cycle.
REQ-016 start SHALL be ignored in every non-IDLE state; latched cnt and hold SHALL not change mid-command.
REQ-017 S1->S2->S3 SHALL be unconditional, one cycle each.
REQ-018 From S3: if latched hold!=0, the FSM SHALL load hold_ctr=hold and enter HOLD; otherwise the pattern SHALL complete.
REQ-019 HOLD SHALL last exactly `hold` cycles (hold_ctr decrements each cycle); when hold_ctr==1 the pattern SHALL complete.
REQ-020 On pattern completion, emitted SHALL increment by 1 and remaining SHALL decrement by 1, both in the same edge.
REQ-021 On completion, if the decremented remaining is 0, the FSM SHALL enter IDLE and assert done for that first IDLE cycle; otherwise it SHALL enter GAP.
REQ-022 GAP SHALL last GAP_LEN cycles, then enter S1.
REQ-023 Busy duration SHALL be cnt*(3+hold) + (cnt-1)*GAP_LEN cycles.
REQ-024 done SHALL be high for exactly one cycle per accepted command and never while busy=1.
REQ-025 A start sampled in the IDLE cycle where done=1 SHALL be accepted, giving back-to-back commands separated by one num=00 cycle.
REQ-026 emitted SHALL hold its value in IDLE until the next accepted start; the maximum value is 15, so no wrap occurs.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, num=00, busy=0, done=0, emitted=0, remaining=0, hold_ctr=0.
REQ-028 reset asserted mid-command SHALL abort the command with no done pulse; after release the block SHALL wait in IDLE for a new start.
REQ-029 A start coincident with the first clk edge after reset release SHALL be accepted normally.

Verification
REQ-030 Single pattern: reset, then start with cnt=1, hold=0 -> num 01,10,11 in the next three cycles; busy=1 for those 3 cycles; done=1 in the 4th with num=00; emitted=1.
REQ-031 Multi-pattern with hold (GAP_LEN=1): cnt=2, hold=2 -> num 01,10,11,11,11,00,01,10,11,11,11 (busy 11 cycles), then done pulse; emitted=2.
REQ-032 Zero count: start with cnt=0 -> busy stays 0, num stays 00, done=1 for one cycle, emitted=0.
REQ-033 Ignored start: cnt=3, hold=0; pulse start with cnt=1 during S2 -> full 3-pattern stream continues unchanged (busy 11 cycles); emitted=3.
REQ-034 Async reset mid-HOLD: cnt=2, hold=3; assert reset between clock edges in the 2nd HOLD cycle -> num=00, busy=0, emitted=0 before the next edge; no done after release.
REQ-035 Back-to-back: start held at 1 with cnt=1, hold=0 -> 01,10,11,00(done=1),01,10,11,00(done=1),... repeating.
